// File: rtl/apb_regbank_pkg.sv
// apb_regbank_pkg
// Shared definitions for the APB slave register bank: the phase-tracking
// FSM encoding, register index map, STATUS bit position and counter width.
// Imported by apb_phase_fsm and apb_slave_regbank.
package apb_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic [3:0] IDX_IRQ_MASK = 4'd13;
  localparam logic [3:0] IDX_RDCNT    = 4'd14;
  localparam logic [3:0] IDX_STATUS   = 4'd15;

  localparam int ERR_BIT = 31;
  localparam int CNT_W   = 16;

  // Indices 14 and 15 are read-only words; everything below is plain storage
  function automatic logic is_rw_idx(input logic [3:0] idx);
    return (idx != IDX_RDCNT) && (idx != IDX_STATUS);
  endfunction

endpackage

// File: rtl/apb_phase_fsm.sv
// apb_phase_fsm
// Tracks the APB phase sequence seen from the bridge, flags protocol
// violations and captures the transfer attributes at SETUP entry.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   sel           this slave's select bit
//   penable       APB access-phase strobe
//   pwrite        transfer direction (1 = write)
//   idx           decoded word index (Paddr[5:2])
//   pwdata        write data
//   state         current phase state
//   setup_entry   high in the cycle whose closing edge enters SETUP
//   err_set       a violation is present this cycle
//   lat_idx/lat_write/lat_wdata  attributes latched at SETUP entry
module apb_phase_fsm
  import apb_regbank_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  idx,
  input  logic [31:0] pwdata,
  output apb_state_t  state,
  output logic        setup_entry,
  output logic        err_set,
  output logic [3:0]  lat_idx,
  output logic        lat_write,
  output logic [31:0] lat_wdata
);

  apb_state_t next_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The FSM lags the bus by one cycle: state SETUP coincides with the bus
  // access phase, so the address/direction consistency check is made on
  // the SETUP -> ACCESS transition.
  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel && penable) begin
          err_set = 1'b1;
        end else if (sel) begin
          next_state = SETUP;
        end
      end
      SETUP: begin
        if (!sel) begin
          next_state = IDLE;
          err_set    = 1'b1;
        end else if (penable) begin
          next_state = ACCESS;
          if ((idx != lat_idx) || (pwrite != lat_write)) begin
            err_set = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (sel && !penable) begin
          next_state = SETUP;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Extended setup (SETUP -> SETUP) is not an entry, so the latched values
  // stay those of the first setup cycle.
  assign setup_entry = (state != SETUP) && (next_state == SETUP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
    end else if (setup_entry) begin
      lat_idx   <= idx;
      lat_write <= pwrite;
      lat_wdata <= pwdata;
    end
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank
// APB slave with 14 R/W registers, a completed-read counter (idx 14) and
// a STATUS word (idx 15) = {err_flag, 15'b0, write count}.
// Optional macro APB_REGBANK_IRQ_EN adds a registered irq output driven by
// err_flag masked with bit 0 of register 13 (IRQ_MASK).
// Ports:
//   Hclk, Hreset  clock, asynchronous active-high reset
//   Pselx         one-hot selects; bit SEL_IDX selects this slave
//   Penable, Pwrite, Paddr, Pwdata  APB request (Paddr[5:2] decoded)
//   Prdata        registered read data
//   err_flag      sticky protocol-violation flag (W1C via STATUS bit 31)
//   irq           (APB_REGBANK_IRQ_EN only) masked error interrupt
module apb_slave_regbank
  import apb_regbank_pkg::*;
#(
  parameter int          SEL_IDX   = 0,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        err_flag
`ifdef APB_REGBANK_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic             sel;
  logic [3:0]       idx;
  apb_state_t       state;
  logic             setup_entry;
  logic             err_set;
  logic [3:0]       lat_idx;
  logic             lat_write;
  logic [31:0]      lat_wdata;
  logic             wr_commit;
  logic             rd_done;
  logic             err_clear;
  logic [31:0]      rd_mux;
  logic [31:0]      regs [0:13];
  logic [CNT_W-1:0] wrcnt;
  logic [CNT_W-1:0] rdcnt;
  logic             unused_bits;

  assign sel         = Pselx[SEL_IDX];
  assign idx         = Paddr[5:2];
  assign unused_bits = ^{Paddr[31:6], Paddr[1:0], Pselx};

  apb_phase_fsm u_fsm (
    .clk         (Hclk),
    .rst         (Hreset),
    .sel         (sel),
    .penable     (Penable),
    .pwrite      (Pwrite),
    .idx         (idx),
    .pwdata      (Pwdata),
    .state       (state),
    .setup_entry (setup_entry),
    .err_set     (err_set),
    .lat_idx     (lat_idx),
    .lat_write   (lat_write),
    .lat_wdata   (lat_wdata)
  );

  // Every ACCESS cycle is followed by leaving ACCESS, so the transfer
  // completes on the edge that closes it.
  assign wr_commit = (state == ACCESS) && lat_write;
  assign rd_done   = (state == ACCESS) && !lat_write;
  assign err_clear = wr_commit && (lat_idx == IDX_STATUS) && lat_wdata[ERR_BIT];

  // Read mux for the index on the bus at SETUP entry. A back-to-back write
  // to the same register commits on that same edge, so its data is
  // forwarded to keep "written value readable by the next transfer" true.
  // Counter words show their pre-increment value in that corner.
  always_comb begin
    rd_mux = '0;
    if (idx == IDX_RDCNT) begin
      rd_mux = {{(32-CNT_W){1'b0}}, rdcnt};
    end else if (idx == IDX_STATUS) begin
      rd_mux = {err_flag, {(31-CNT_W){1'b0}}, wrcnt};
    end else if (wr_commit && (lat_idx == idx)) begin
      rd_mux = lat_wdata;
    end else begin
      rd_mux = regs[idx];
    end
  end

  // Register array: writes to the read-only words are dropped silently
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      for (int i = 0; i < 14; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (wr_commit && is_rw_idx(lat_idx)) begin
      regs[lat_idx] <= lat_wdata;
    end
  end

  // Transfer counters, wrapping naturally at their width
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      wrcnt <= '0;
      rdcnt <= '0;
    end else begin
      if (wr_commit) begin
        wrcnt <= wrcnt + CNT_W'(1);
      end
      if (rd_done) begin
        rdcnt <= rdcnt + CNT_W'(1);
      end
    end
  end

  // Read data is captured at SETUP entry and then held until the next read
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      Prdata <= '0;
    end else if (setup_entry && !Pwrite) begin
      Prdata <= rd_mux;
    end
  end

  // Sticky error flag; a new violation takes priority over a W1C clear
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      err_flag <= 1'b0;
    end else if (err_set) begin
      err_flag <= 1'b1;
    end else if (err_clear) begin
      err_flag <= 1'b0;
    end
  end

`ifdef APB_REGBANK_IRQ_EN
  // Registered interrupt, one cycle behind err_flag
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      irq <= 1'b0;
    end else begin
      irq <= err_flag & regs[IDX_IRQ_MASK][0];
    end
  end
`endif

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb_apb_slave_regbank
// Self-checking bench for apb_slave_regbank (SEL_IDX = 0). Expected read
// data comes from a small register/counter model and is queued when a
// transfer is issued, then popped and compared when Prdata is sampled.
// Define APB_REGBANK_IRQ_EN to also exercise the irq output.
module tb_apb_slave_regbank;
  import apb_regbank_pkg::*;

  localparam int          SEL       = 0;
  localparam logic [31:0] RV        = 32'h0000_0000;
  localparam logic [2:0]  SEL_MASK  = 3'b001;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        err_flag;
`ifdef APB_REGBANK_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_reg [0:13];
  logic [15:0] m_wr;
  logic [15:0] m_rd;
  logic        m_err;

  apb_slave_regbank #(
    .SEL_IDX   (SEL),
    .RESET_VAL (RV)
  ) dut (
    .Hclk     (hclk),
    .Hreset   (hreset),
    .Pselx    (pselx),
    .Penable  (penable),
    .Pwrite   (pwrite),
    .Paddr    (paddr),
    .Pwdata   (pwdata),
    .Prdata   (prdata),
    .err_flag (err_flag)
`ifdef APB_REGBANK_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 hclk = ~hclk;

  function automatic logic [31:0] model_read(input logic [3:0] i);
    if (i == 4'd14) return {16'h0000, m_rd};
    if (i == 4'd15) return {m_err, 15'b0, m_wr};
    return m_reg[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 14; i++) m_reg[i] = RV;
    m_wr  = '0;
    m_rd  = '0;
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge hclk);
    hreset = 1'b1;
    @(negedge hclk);
    hreset = 1'b0;
    model_reset();
  endtask

  // One non-overlapped transfer; rdata is sampled during the access phase
  task automatic bus_xfer(input logic [2:0] psel, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    logic [3:0] i;
    i = addr[5:2];
    @(negedge hclk);
    pselx = psel; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge hclk);
    penable = 1'b1;
    rdata = prdata;
    @(negedge hclk);
    pselx = 3'b000; penable = 1'b0;
    @(negedge hclk);
    if (psel[SEL]) begin
      if (wr) begin
        m_wr = m_wr + 16'd1;
        if (i < 4'd14) m_reg[i] = wdata;
        if (i == 4'd15 && wdata[31]) m_err = 1'b0;
      end else begin
        m_rd = m_rd + 16'd1;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    hreset = 1'b1; pselx = '0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    model_reset();
    @(negedge hclk);
    @(negedge hclk);
    checks++;
    if (prdata !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_prdata: got %h expected %h", prdata, 32'h0);
    end
    checks++;
    if (err_flag !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_err: got %b expected 0", err_flag);
    end
`ifdef APB_REGBANK_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    end
`endif
    hreset = 1'b0;
    for (int k = 0; k < 14; k += 13) begin
      exp_q.push_back(model_read(4'(k)));
      bus_xfer(SEL_MASK, 1'b0, 32'(k * 4), 32'h0, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++; $display("[TB] FAIL reset_reg%0d: got %h expected %h", k, got, exp);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] got, exp;
    do_reset();
    bus_xfer(SEL_MASK, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, got);
    exp_q.push_back(32'hDEAD_BEEF);
    bus_xfer(SEL_MASK, 1'b0, 32'h8000_0008, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL read_idx2: got %h expected %h", got, exp);
    end
    exp_q.push_back(model_read(4'd14));
    bus_xfer(SEL_MASK, 1'b0, 32'h0000_0039, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || got !== 32'h1) begin
      failures++; $display("[TB] FAIL read_rdcnt: got %h expected %h", got, exp);
    end
    exp_q.push_back(model_read(4'd15));
    bus_xfer(SEL_MASK, 1'b0, 32'hFFFF_FFFC, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || got !== 32'h1) begin
      failures++; $display("[TB] FAIL read_status: got %h expected %h", got, exp);
    end
    // Prdata holds after the transfer
    checks++;
    if (prdata !== 32'h1) begin
      failures++; $display("[TB] FAIL prdata_hold: got %h expected %h", prdata, 32'h1);
    end
  endtask

  task automatic test_unselected();
    logic [31:0] got, exp;
    bus_xfer(3'b010, 1'b1, 32'h0000_0008, 32'h1234_5678, got);
    checks++;
    if (err_flag !== 1'b0) begin
      failures++; $display("[TB] FAIL unsel_err: got %b expected 0", err_flag);
    end
    exp_q.push_back(model_read(4'd2));
    bus_xfer(SEL_MASK, 1'b0, 32'h0000_0008, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL unsel_reg: got %h expected %h", got, exp);
    end
    exp_q.push_back(model_read(4'd15));
    bus_xfer(SEL_MASK, 1'b0, 32'h0000_003C, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL unsel_wrcnt: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp;
    @(negedge hclk);
    pselx = SEL_MASK; penable = 0; pwrite = 1; paddr = 32'h00; pwdata = 32'h1;
    @(negedge hclk); penable = 1;
    @(negedge hclk); penable = 0; paddr = 32'h04; pwdata = 32'h2;
    @(negedge hclk); penable = 1;
    @(negedge hclk); pselx = '0; penable = 0;
    @(negedge hclk);
    m_reg[0] = 32'h1; m_reg[1] = 32'h2; m_wr = m_wr + 16'd2;
    checks++;
    if (err_flag !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_err: got %b expected 0", err_flag);
    end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(model_read(4'(k)));
      bus_xfer(SEL_MASK, 1'b0, 32'(k * 4), 32'h0, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++; $display("[TB] FAIL b2b_reg%0d: got %h expected %h", k, got, exp);
      end
    end
    exp_q.push_back(model_read(4'd15));
    bus_xfer(SEL_MASK, 1'b0, 32'h3C, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL b2b_wrcnt: got %h expected %h", got, exp);
    end
    // Write immediately followed by a read of the same register
    @(negedge hclk);
    pselx = SEL_MASK; penable = 0; pwrite = 1; paddr = 32'h0C; pwdata = 32'hA5A5_0003;
    @(negedge hclk); penable = 1;
    m_reg[3] = 32'hA5A5_0003; m_wr = m_wr + 16'd1;
    exp_q.push_back(model_read(4'd3));
    @(negedge hclk); penable = 0; pwrite = 0;
    @(negedge hclk); penable = 1;
    got = prdata;
    @(negedge hclk); pselx = '0; penable = 0;
    @(negedge hclk);
    m_rd = m_rd + 16'd1;
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL raw_fwd: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_violation();
    logic [31:0] got, exp;
    // Enable without setup
    @(negedge hclk);
    pselx = SEL_MASK; penable = 1; pwrite = 0; paddr = 32'h0;
    @(negedge hclk);
    pselx = '0; penable = 0;
    m_err = 1'b1;
    checks++;
    if (err_flag !== 1'b1) begin
      failures++; $display("[TB] FAIL viol_idle_en: got %b expected 1", err_flag);
    end
    exp_q.push_back(model_read(4'd15));
    bus_xfer(SEL_MASK, 1'b0, 32'h3C, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL viol_status: got %h expected %h", got, exp);
    end
    bus_xfer(SEL_MASK, 1'b1, 32'h3C, 32'h8000_0000, got);
    checks++;
    if (err_flag !== 1'b0) begin
      failures++; $display("[TB] FAIL w1c_clear: got %b expected 0", err_flag);
    end
    // Address changes between setup and access: flagged, latched values used
    @(negedge hclk);
    pselx = SEL_MASK; penable = 0; pwrite = 1; paddr = 32'h10; pwdata = 32'h4444_0004;
    @(negedge hclk); penable = 1; paddr = 32'h14; pwdata = 32'h5555_0005;
    @(negedge hclk); pselx = '0; penable = 0;
    m_err = 1'b1;
    checks++;
    if (err_flag !== 1'b1) begin
      failures++; $display("[TB] FAIL viol_mismatch: got %b expected 1", err_flag);
    end
    @(negedge hclk);
    m_reg[4] = 32'h4444_0004; m_wr = m_wr + 16'd1;
    for (int k = 4; k < 6; k++) begin
      exp_q.push_back(model_read(4'(k)));
      bus_xfer(SEL_MASK, 1'b0, 32'(k * 4), 32'h0, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++; $display("[TB] FAIL mismatch_reg%0d: got %h expected %h", k, got, exp);
      end
    end
    bus_xfer(SEL_MASK, 1'b1, 32'h3C, 32'h8000_0000, got);
    // Aborted transfer: select drops while in SETUP
    @(negedge hclk);
    pselx = SEL_MASK; penable = 0; pwrite = 1; paddr = 32'h18; pwdata = 32'h6;
    @(negedge hclk); pselx = '0;
    @(negedge hclk);
    m_err = 1'b1;
    checks++;
    if (err_flag !== 1'b1) begin
      failures++; $display("[TB] FAIL viol_abort: got %b expected 1", err_flag);
    end
    exp_q.push_back(model_read(4'd6));
    bus_xfer(SEL_MASK, 1'b0, 32'h18, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL abort_reg6: got %h expected %h", got, exp);
    end
    bus_xfer(SEL_MASK, 1'b1, 32'h3C, 32'h8000_0000, got);
  endtask

  task automatic test_counter_wrap();
    logic [31:0] got, exp;
    @(negedge hclk);
    force dut.wrcnt = 16'hFFFE;
    @(negedge hclk);
    release dut.wrcnt;
    m_wr = 16'hFFFE;
    bus_xfer(SEL_MASK, 1'b1, 32'h1C, 32'h7, got);
    bus_xfer(SEL_MASK, 1'b1, 32'h20, 32'h8, got);
    exp_q.push_back(model_read(4'd15));
    bus_xfer(SEL_MASK, 1'b0, 32'h3C, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || got[15:0] !== 16'h0000) begin
      failures++; $display("[TB] FAIL wrcnt_wrap: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp;
    bus_xfer(SEL_MASK, 1'b1, 32'h14, 32'h5555_AAAA, got);
    exp_q.push_back(model_read(4'd5));
    bus_xfer(SEL_MASK, 1'b0, 32'h14, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL pre_reset_reg5: got %h expected %h", got, exp);
    end
    @(negedge hclk);
    pselx = SEL_MASK; penable = 0; pwrite = 1; paddr = 32'h14; pwdata = 32'h1111_1111;
    @(negedge hclk); penable = 1;
    @(negedge hclk); pselx = '0; penable = 0;
    hreset = 1'b1;
    #1;
    checks++;
    if (prdata !== 32'h0) begin
      failures++; $display("[TB] FAIL mid_reset_prdata: got %h expected %h", prdata, 32'h0);
    end
    @(negedge hclk);
    hreset = 1'b0;
    model_reset();
    exp_q.push_back(model_read(4'd5));
    bus_xfer(SEL_MASK, 1'b0, 32'h14, 32'h0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL mid_reset_reg5: got %h expected %h", got, exp);
    end
  endtask

`ifdef APB_REGBANK_IRQ_EN
  task automatic test_irq();
    logic [31:0] got;
    bus_xfer(SEL_MASK, 1'b1, 32'h34, 32'h1, got);
    @(negedge hclk);
    pselx = SEL_MASK; penable = 0; pwrite = 0; paddr = 32'h0;
    @(negedge hclk); pselx = '0;
    @(negedge hclk);
    checks++;
    if (err_flag !== 1'b1 || irq !== 1'b0) begin
      failures++; $display("[TB] FAIL irq_lag: got err=%b irq=%b expected err=1 irq=0", err_flag, irq);
    end
    @(negedge hclk);
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("[TB] FAIL irq_set: got %b expected 1", irq);
    end
    bus_xfer(SEL_MASK, 1'b1, 32'h3C, 32'h8000_0000, got);
    @(negedge hclk);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("[TB] FAIL irq_clear: got %b expected 0", irq);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_unselected();
    test_back_to_back();
    test_violation();
    test_counter_wrap();
    test_reset_mid();
`ifdef APB_REGBANK_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
